interp_ctrl: RTL

Sequencer and configuration controller for the interpolator FIR datapath. Accepts one input sample per handshake, expands it into L filter beats (the sample, then L-1 zeros) toward the FIR, and owns the FIR's coefficient and bypass configuration. Coefficients are loaded serially into a shadow bank and swapped into the active bank only on a frame boundary, so the FIR never sees a mixed coefficient set mid-expansion.

---
 rtl/interp_pkg.sv | 28 ++
 rtl/interp_ctrl_coeff_bank.sv | 97 +++++++++
 rtl/interp_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/interp_pkg.sv
// Shared types and helpers for the interpolator sequencer.
package interp_pkg;

    // Controller phases: waiting for a sample, emitting it, emitting zero fill.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        ZERO   = 2'd2
    } state_t;

    // Bits needed to hold every factor value from 0 up to max_factor.
    function automatic int fw_width(input int max_factor);
        return $clog2(max_factor + 1);
    endfunction

    // A requested factor of 0 means "no interpolation" (one beat); anything
    // above the supported maximum saturates rather than wrapping.
    function automatic int clamp_factor(input int factor, input int max_factor);
        if (factor == 0) begin
            return 1;
        end else if (factor > max_factor) begin
            return max_factor;
        end else begin
            return factor;
        end
    endfunction

endpackage

// File: rtl/interp_ctrl_coeff_bank.sv
// Shadow/active coefficient storage. Coefficients are pushed serially into the
// shadow bank; a commit arms a swap that the controller lets through only while
// idle, so the FIR always sees one complete coefficient set per frame.
module coeff_bank
    import interp_pkg::*;
#(
    parameter int COEFF_WORD_SIZE = 16,
    parameter int N_COEFFS        = 5
) (
    input  logic                                clk,
    input  logic                                arst,
    input  logic                                i_wr_en,
    input  logic [COEFF_WORD_SIZE-1:0]          i_wr_data,
    input  logic                                i_commit,
    input  logic                                i_idle,
    output logic                                o_swap_pending,
    output logic [N_COEFFS*COEFF_WORD_SIZE-1:0] o_coeff,
    output logic                                o_err
);

    localparam int             IW   = $clog2(N_COEFFS + 1);
    localparam logic [IW-1:0]  FULL = IW'(N_COEFFS);

    logic [IW-1:0] r_wr_idx;
    logic [IW-1:0] w_wr_idx_next;
    logic [IW-1:0] w_idx_after_wr;
    logic          r_swap_pending;
    logic          w_swap_pending_next;
    logic          r_err;
    logic          w_err_next;
    logic          w_wr_accept;
    logic          w_swap;

    // Write/commit/swap bookkeeping. A commit is judged on the index after any
    // write in the same cycle, so "write last coeff + commit" together works.
    always_comb begin
        w_wr_accept         = i_wr_en && (r_wr_idx != FULL) && !r_swap_pending;
        w_swap              = i_idle && r_swap_pending;
        w_idx_after_wr      = w_wr_accept ? (r_wr_idx + 1'b1) : r_wr_idx;
        w_wr_idx_next       = w_idx_after_wr;
        w_swap_pending_next = r_swap_pending;
        w_err_next          = i_wr_en && !w_wr_accept;
        if (i_commit) begin
            if ((w_idx_after_wr == FULL) && !r_swap_pending) begin
                w_swap_pending_next = 1'b1;
            end else begin
                // Incomplete or duplicate commit: force a full shadow reload.
                w_err_next    = 1'b1;
                w_wr_idx_next = '0;
            end
        end
        if (w_swap) begin
            w_swap_pending_next = 1'b0;
            w_wr_idx_next       = '0;
        end
    end

    // Control registers: write pointer, armed swap and the registered error pulse.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_wr_idx       <= '0;
            r_swap_pending <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_wr_idx       <= w_wr_idx_next;
            r_swap_pending <= w_swap_pending_next;
            r_err          <= w_err_next;
        end
    end

    // One shadow/active register pair per tap; tap 0 sits in the LSBs of o_coeff.
    for (genvar gi = 0; gi < N_COEFFS; gi++) begin : g_tap
        logic [COEFF_WORD_SIZE-1:0] r_shadow;
        logic [COEFF_WORD_SIZE-1:0] r_active;

        // Capture a pushed coefficient at its slot; copy to active on swap.
        always_ff @(posedge clk or posedge arst) begin
            if (arst) begin
                r_shadow <= '0;
                r_active <= '0;
            end else begin
                if (w_wr_accept && (r_wr_idx == IW'(gi))) begin
                    r_shadow <= i_wr_data;
                end
                if (w_swap) begin
                    r_active <= r_shadow;
                end
            end
        end

        assign o_coeff[gi*COEFF_WORD_SIZE +: COEFF_WORD_SIZE] = r_active;
    end

    assign o_swap_pending = r_swap_pending;
    assign o_err          = r_err;

endmodule

// File: rtl/interp_ctrl.sv
// Interpolator sequencer: expands each accepted sample into L FIR beats (the
// sample followed by L-1 zeros) and owns the FIR bypass and coefficient config.
module interp_ctrl
    import interp_pkg::*;
#(
    parameter int INPUT_WORD_SIZE = 16,
    parameter int COEFF_WORD_SIZE = 16,
    parameter int N_COEFFS        = 5,
    parameter int MAX_FACTOR      = 8,
    parameter int FW              = fw_width(MAX_FACTOR)
) (
    input  logic                                clk,
    input  logic                                arst,
    input  logic [FW-1:0]                       factor,
    input  logic                                bypass,
    input  logic [INPUT_WORD_SIZE-1:0]          data_in,
    input  logic                                valid_in,
    output logic                                src_ready_out,
    output logic [INPUT_WORD_SIZE-1:0]          fir_data,
    output logic                                fir_valid,
    input  logic                                fir_ready,
    output logic                                fir_bypass,
    output logic [N_COEFFS*COEFF_WORD_SIZE-1:0] coeff,
    input  logic                                coeff_wr_en,
    input  logic [COEFF_WORD_SIZE-1:0]          coeff_wr_data,
    input  logic                                coeff_commit,
    output logic                                coeff_err,
    output logic                                busy
);

    state_t                     r_state;
    state_t                     w_state_next;
    logic [INPUT_WORD_SIZE-1:0] r_sample;
    logic [FW-1:0]              r_len;
    logic [FW-1:0]              r_phase;
    logic [FW-1:0]              w_phase_next;
    logic [FW-1:0]              w_len_new;
    logic                       w_load;
    logic                       w_last;
    logic                       w_src_ready;
    logic                       w_fir_valid;
    logic [INPUT_WORD_SIZE-1:0] w_fir_data;
    logic                       r_bypass;
    logic                       w_swap_pending;
    logic                       w_idle;

    assign w_len_new = FW'(clamp_factor(int'(factor), MAX_FACTOR));
    assign w_idle    = (r_state == IDLE);

    // State register.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and handshake outputs. On the last beat of a frame the next
    // sample is taken in the same cycle so the FIR stream has no bubbles; a
    // pending coefficient swap instead forces a return to IDLE to apply it.
    always_comb begin
        w_state_next = r_state;
        w_phase_next = r_phase;
        w_src_ready  = 1'b0;
        w_fir_valid  = 1'b0;
        w_fir_data   = '0;
        w_last       = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                w_src_ready = !w_swap_pending;
                if (valid_in && !w_swap_pending) begin
                    w_load       = 1'b1;
                    w_state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                w_fir_valid = 1'b1;
                w_fir_data  = r_sample;
                w_last      = (r_len == FW'(1));
                if (fir_ready && !w_last) begin
                    w_state_next = ZERO;
                    w_phase_next = FW'(1);
                end
            end
            ZERO: begin
                w_fir_valid = 1'b1;
                w_last      = (r_phase == (r_len - FW'(1)));
                if (fir_ready && !w_last) begin
                    w_phase_next = r_phase + FW'(1);
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        if (w_last && fir_ready) begin
            w_src_ready = !w_swap_pending;
            if (valid_in && !w_swap_pending) begin
                w_load       = 1'b1;
                w_state_next = SAMPLE;
            end else begin
                w_state_next = IDLE;
            end
        end
    end

    // Sample, frame length and zero-beat phase counter.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_sample <= '0;
            r_len    <= FW'(1);
            r_phase  <= '0;
        end else begin
            r_phase <= w_phase_next;
            if (w_load) begin
                r_sample <= data_in;
                r_len    <= w_len_new;
            end
        end
    end

    // Bypass follows the request only between frames so a frame is never split.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_bypass <= 1'b0;
        end else if (w_idle) begin
            r_bypass <= bypass;
        end
    end

    coeff_bank #(
        .COEFF_WORD_SIZE (COEFF_WORD_SIZE),
        .N_COEFFS        (N_COEFFS)
    ) u_coeff_bank (
        .clk            (clk),
        .arst           (arst),
        .i_wr_en        (coeff_wr_en),
        .i_wr_data      (coeff_wr_data),
        .i_commit       (coeff_commit),
        .i_idle         (w_idle),
        .o_swap_pending (w_swap_pending),
        .o_coeff        (coeff),
        .o_err          (coeff_err)
    );

    assign src_ready_out = w_src_ready;
    assign fir_valid     = w_fir_valid;
    assign fir_data      = w_fir_data;
    assign fir_bypass    = r_bypass;
    assign busy          = !w_idle;

endmodule
